sys_result_drain: RTL and testbench
===================================

SYS_RESULT_DRAIN -- requirements
Module: sys_result_drain

Interface
REQ-001 Parameter OUT_WIDTH SHALL default to 16 and give the width of each array result word; only 16 is required to be supported.
REQ-002 Parameter NUM_RESULTS SHALL default to 16 and give the number of result words per frame.
REQ-003 Parameter HEADER SHALL default to 8'hA5 and give the frame-start byte.
REQ-004 clk SHALL be an input, 1 bit, the single rising-edge clock.
REQ-005 reset SHALL be an input, 1 bit, a synchronous active-high reset.
REQ-006 done_in SHALL be an input, 1 bit, the array completion strobe.
REQ-007 c_flat SHALL be an input, NUM_RESULTS*OUT_WIDTH bits, carrying the results; C0 is at bits [15:0] and Ck at bits [16k+15:16k].
REQ-008 tx_data SHALL be an output, 8 bits, the byte offered to the UART transmitter.
REQ-009 tx_valid SHALL be an output, 1 bit, asserted when tx_data holds a valid byte.
REQ-010 tx_ready SHALL be an input, 1 bit, asserted when the UART transmitter accepts a byte.
REQ-011 busy SHALL be an output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 frame_done SHALL be an output, 1 bit, a one-cycle pulse after the checksum byte transfers.
REQ-013 overrun SHALL be an output, 1 bit, a sticky flag set when a done_in strobe is dropped.

Function
REQ-014 The FSM SHALL have four states: IDLE, HEADER, DATA and CSUM.
REQ-015 In IDLE, done_in=1 at a clock edge SHALL latch all of c_flat into an internal frame buffer on that edge and move the FSM to HEADER.
REQ-016 tx_valid SHALL rise in the cycle after capture; capture-to-first-tx_valid latency is 1 cycle.
REQ-017 A byte transfer SHALL occur on an edge where tx_valid=1 and tx_ready=1.
REQ-018 While tx_valid=1 and no transfer has occurred, tx_data SHALL remain stable and tx_valid SHALL remain high.
REQ-019 After each transfer, the next byte (if any) SHALL be presented in the following cycle, giving a maximum throughput of 1 byte per cycle with tx_ready held high.
REQ-020 Each frame SHALL be sent in this order: HEADER; then C0 to C15, each high byte first and low byte second (32 bytes); then the checksum.
REQ-021 The checksum SHALL be the modulo-256 sum of the 32 data bytes, excluding the header.
REQ-022 The checksum SHALL be accumulated at transfer time in an 8-bit register that wraps without carry-out.
REQ-023 A 5-bit byte index SHALL count 0 to 31 in DATA; on the transfer at index 31 the FSM SHALL move to CSUM and the index SHALL return to 0.
REQ-024 On the CSUM transfer, frame_done SHALL pulse high for exactly 1 cycle (the next cycle) and the FSM SHALL enter IDLE.
REQ-025 If done_in=1 on the same edge as the CSUM transfer, the new c_flat SHALL be captured, the FSM SHALL go directly to HEADER, frame_done SHALL still pulse, and overrun SHALL remain unchanged.
REQ-026 done_in=1 in HEADER, DATA, or CSUM without a CSUM transfer on that edge SHALL be ignored: the frame buffer is unchanged and overrun is set to 1.
REQ-027 overrun SHALL clear only on reset.
REQ-028 The frame buffer SHALL be unaffected by changes on c_flat except at a capture edge.
REQ-029 tx_ready high while tx_valid=0 SHALL have no effect.
REQ-030 tx_data SHALL be 0 whenever tx_valid=0.
REQ-031 done_in held high for multiple cycles SHALL count as one capture on the first edge; each later high edge while busy is an overrun, except as stated in REQ-025.

Reset
REQ-032 On a reset edge, the FSM SHALL go to IDLE and the following SHALL be set: tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0, byte index=0, checksum=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; no further bytes are offered, and the next done_in starts a fresh frame with the header.
REQ-034 Reset SHALL take priority over done_in and tx_ready on the same edge.
REQ-035 The frame buffer contents need not be reset.

Verification
REQ-036 Test 1: with c_flat C0=16'h0102, all other results 0, done_in pulsed, and tx_ready=1 constantly, the bench SHALL see 34 consecutive bytes A5, 01, 02, then 30 x 00, then 03, followed by a frame_done pulse and busy=0.
REQ-037 Test 2: with every Ck=16'hFFFF, the bench SHALL see a checksum of 8'hE0 (32*255 mod 256) and data bytes that are all FF.
REQ-038 Test 3: with tx_ready toggled randomly and held low for 5 cycles on the header, tx_data SHALL stay A5 with tx_valid high for the whole stall, and the byte stream SHALL be identical to Test 1.
REQ-039 Test 4: with done_in pulsed again at data byte 10, overrun SHALL become 1 and stay 1, the frame SHALL complete unchanged, and no second frame SHALL follow.
REQ-040 Test 5: with done_in asserted on the edge of the CSUM transfer carrying new data (C0=16'h0A0B), frame_done SHALL pulse, the next frame SHALL start with no idle gap as A5, 0A, 0B, and overrun SHALL stay 0.
REQ-041 Test 6: with reset asserted after data byte 7, tx_valid, busy and overrun SHALL be 0 in the next cycle, and a subsequent done_in SHALL produce a full 34-byte frame beginning with A5.

Source files
------------

// File: rtl/sys_result_drain.sv
// sys_result_drain: captures an array result frame on done_in and streams it
// as header, big-endian result bytes and a mod-256 checksum over a valid/ready byte port.
module sys_result_drain #(
    parameter int          OUT_WIDTH   = 16,
    parameter int          NUM_RESULTS = 16,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             done_in,
    input  logic [NUM_RESULTS*OUT_WIDTH-1:0] c_flat,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             overrun
);
    localparam int NB = NUM_RESULTS * OUT_WIDTH / 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CSUM} state_t;

    state_t                           state_q, state_d;
    logic [NUM_RESULTS*OUT_WIDTH-1:0] buf_q, buf_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [7:0]                       csum_q, csum_d;
    logic                             fd_q, fd_d;
    logic                             ov_q, ov_d;
    logic [7:0]                       data_byte;
    logic                             xfer, csum_xfer;

    // Even index is the high byte of a word, so the bit offset is 8*(idx^1).
    assign data_byte  = buf_q[{idx_q ^ IW'(1), 3'b000} +: 8];
    assign tx_valid   = state_q != ST_IDLE;
    assign busy       = state_q != ST_IDLE;
    assign xfer       = tx_valid && tx_ready;
    assign csum_xfer  = state_q == ST_CSUM && xfer;
    assign tx_data    = state_q == ST_HDR  ? HEADER :
                        state_q == ST_DATA ? data_byte :
                        state_q == ST_CSUM ? csum_q : 8'h00;
    assign frame_done = fd_q;
    assign overrun    = ov_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        fd_d    = 1'b0;
        ov_d    = ov_q;
        case (state_q)
            ST_IDLE: if (done_in) begin
                buf_d   = c_flat;
                state_d = ST_HDR;
            end
            ST_HDR: if (xfer) state_d = ST_DATA;
            ST_DATA: if (xfer) begin
                csum_d  = csum_q + data_byte;
                idx_d   = idx_q == LAST ? '0 : idx_q + IW'(1);
                state_d = idx_q == LAST ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: if (xfer) begin
                fd_d    = 1'b1;
                csum_d  = 8'h00;
                state_d = done_in ? ST_HDR : ST_IDLE;
                buf_d   = done_in ? c_flat : buf_q;
            end
            default: state_d = ST_IDLE;
        endcase
        // A strobe landing exactly on the checksum transfer is a back-to-back capture, not a drop.
        if (done_in && state_q != ST_IDLE && !csum_xfer)
            ov_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            fd_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            fd_q    <= fd_d;
            ov_q    <= ov_d;
        end
    end

    always_ff @(posedge clk) buf_q <= buf_d;
endmodule

// File: tb/tb_sys_result_drain.sv
// tb_sys_result_drain: byte-queue reference model plus directed frame scenarios
// and a randomized traffic phase for sys_result_drain.
module tb_sys_result_drain;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         done_in = 1'b0;
    logic [255:0] c_flat = '0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic       m_fd = 1'b0;
    logic       m_ov = 1'b0;

    sys_result_drain dut (
        .clk(clk), .reset(reset), .done_in(done_in), .c_flat(c_flat),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [255:0] c);
        logic [7:0]  s;
        logic [15:0] w;
        s = 8'h00;
        mq.push_back(8'hA5);
        for (int k = 0; k < 16; k++) begin
            w = c[16*k +: 16];
            mq.push_back(w[15:8]);
            mq.push_back(w[7:0]);
            s = s + w[15:8] + w[7:0];
        end
        mq.push_back(s);
    endtask

    // Reference model: the frame is just a queue of bytes still owed to the transmitter.
    always @(posedge clk) begin
        bit was_idle, xfer, last;
        if (reset) begin
            mq.delete();
            m_fd = 1'b0;
            m_ov = 1'b0;
        end else begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            was_idle = mq.size() == 0;
            xfer = !was_idle && tx_ready;
            last = xfer && mq.size() == 1;
            m_fd = last;
            if (xfer) void'(mq.pop_front());
            if (done_in) begin
                if (was_idle || last) load(c_flat);
                else m_ov = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("tx_valid", tx_valid, mq.size() > 0);
            chk("tx_data", tx_data, mq.size() > 0 ? mq[0] : 8'h00);
            chk("busy", busy, mq.size() > 0);
            chk("frame_done", frame_done, m_fd);
            chk("overrun", overrun, m_ov);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        done_in = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        armed = 1'b1;
        got.delete();
    endtask

    task automatic pulse();
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (mq.size() > 0 && n < 500) begin
            @(negedge clk);
            tx_ready = rnd ? 1'($urandom % 2) : 1'b1;
            n++;
        end
        if (mq.size() > 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (got.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) chk("wait_bytes_timeout", got.size(), n);
    endtask

    function automatic logic [7:0] t1_byte(input int i);
        return i == 0 ? 8'hA5 : i == 1 ? 8'h01 : i == 2 ? 8'h02 : i == 33 ? 8'h03 : 8'h00;
    endfunction

    initial begin
        logic [255:0] c;
        // Test 1: single nonzero result, ready held high
        do_reset();
        c = '0;
        c[15:0] = 16'h0102;
        c_flat = c;
        tx_ready = 1'b1;
        pulse();
        drain(0);
        chk("t1_frame_done", frame_done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_len", got.size(), 34);
        for (int i = 0; i < 34; i++) chk($sformatf("t1_byte%0d", i), got[i], t1_byte(i));

        // Test 2: all ones
        do_reset();
        c_flat = '1;
        tx_ready = 1'b1;
        pulse();
        drain(0);
        chk("t2_len", got.size(), 34);
        chk("t2_csum", got[33], 8'hE0);
        for (int i = 1; i < 33; i++) chk($sformatf("t2_byte%0d", i), got[i], 8'hFF);

        // Test 3: header stall then random ready
        do_reset();
        c_flat = c;
        tx_ready = 1'b0;
        pulse();
        repeat (5) begin
            chk("t3_stall_valid", tx_valid, 1);
            chk("t3_stall_data", tx_data, 8'hA5);
            @(negedge clk);
        end
        drain(1);
        chk("t3_len", got.size(), 34);
        for (int i = 0; i < 34; i++) chk($sformatf("t3_byte%0d", i), got[i], t1_byte(i));

        // Test 4: dropped strobe mid-frame
        do_reset();
        c_flat = c;
        tx_ready = 1'b1;
        pulse();
        wait_bytes(11);
        c_flat = {16{16'h5555}};
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("t4_overrun", overrun, 1);
        drain(0);
        repeat (5) @(negedge clk);
        chk("t4_len", got.size(), 34);
        chk("t4_busy", busy, 0);
        chk("t4_overrun_sticky", overrun, 1);
        for (int i = 0; i < 34; i++) chk($sformatf("t4_byte%0d", i), got[i], t1_byte(i));

        // Test 5: back-to-back capture on the checksum transfer
        do_reset();
        c_flat = c;
        tx_ready = 1'b1;
        pulse();
        wait_bytes(33);
        c_flat = '0;
        c_flat[15:0] = 16'h0A0B;
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("t5_frame_done", frame_done, 1);
        chk("t5_busy", busy, 1);
        chk("t5_hdr", tx_data, 8'hA5);
        drain(0);
        chk("t5_len", got.size(), 68);
        chk("t5_b34", got[34], 8'hA5);
        chk("t5_b35", got[35], 8'h0A);
        chk("t5_b36", got[36], 8'h0B);
        chk("t5_csum", got[67], 8'h15);
        chk("t5_overrun", overrun, 0);

        // Test 6: reset mid-frame after an overrun
        do_reset();
        c_flat = c;
        tx_ready = 1'b1;
        pulse();
        wait_bytes(4);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        wait_bytes(9);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_valid", tx_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overrun", overrun, 0);
        reset = 1'b0;
        got.delete();
        pulse();
        drain(0);
        chk("t6_len", got.size(), 34);
        chk("t6_hdr", got[0], 8'hA5);
        chk("t6_csum", got[33], 8'h03);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            tx_ready = ($urandom % 3) != 0;
            done_in = ($urandom % 25) == 0;
            reset = ($urandom % 800) == 0;
            for (int k = 0; k < 8; k++) c_flat[32*k +: 32] = $urandom();
        end
        @(negedge clk);
        reset = 1'b0;
        done_in = 1'b0;
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
